lowspeed_arbiter: RTL

LOWSPEED_ARBITER -- requirements
Module: lowspeed_arbiter

---
 rtl/lowspeed_arbiter.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/lowspeed_arbiter.sv
// lowspeed_arbiter: shares one byte-stream command core between two
// requesters (A and B). A requester owns the core from its first command
// byte until the core's response has drained back to it.
//
// Ports
//   clock, reset            posedge clock, synchronous active-low reset
//   a_read_* / b_read_*     requester command bytes in (valid/ready)
//   a_write_* / b_write_*   response bytes out to requesters (valid/ready)
//   core_read_*             command bytes out to the core
//   core_write_*            response bytes in from the core
//   grant_o                 one-hot owner, [0]=A, [1]=B, 00=none
//   error_orphan_o          sticky: core response seen outside DRAIN
//   error_timeout_o         sticky: watchdog fired (0 in default build)
//
// Optional feature: define LOWSPEED_ARB_TIMEOUT_EN to enable the stall
// watchdog and the PAD state. TIMEOUT_CYCLES only matters in that build.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; pick a requester (round-robin on tie)
// CMD   | owner's command bytes forwarded to the core
// PAD   | owner stalled too long; core fed 8'h00 until args are complete
// GUARD | one dead cycle while the core drops read_ready
// DRAIN | core responses routed back to the owner (or discarded after PAD)
module lowspeed_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] a_read_data_i,
    input  logic       a_read_valid_i,
    output logic       a_read_ready_o,
    output logic [7:0] a_write_data_o,
    output logic       a_write_valid_o,
    input  logic       a_write_ready_i,
    input  logic [7:0] b_read_data_i,
    input  logic       b_read_valid_i,
    output logic       b_read_ready_o,
    output logic [7:0] b_write_data_o,
    output logic       b_write_valid_o,
    input  logic       b_write_ready_i,
    output logic [7:0] core_read_data_o,
    output logic       core_read_valid_o,
    input  logic       core_read_ready_i,
    input  logic [7:0] core_write_data_i,
    input  logic       core_write_valid_i,
    output logic       core_write_ready_o,
    output logic [1:0] grant_o,
    output logic       error_orphan_o,
    output logic       error_timeout_o
);

`ifdef LOWSPEED_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, CMD, GUARD, DRAIN, PAD} state_t;
`else
    typedef enum logic [2:0] {IDLE, CMD, GUARD, DRAIN} state_t;
`endif

    state_t     state, state_nx;
    logic       owner, owner_nx;       // 0 = A, 1 = B
    logic       last_b, last_b_nx;     // last completed owner was B
    logic [1:0] args_left, args_nx;
    logic       first_done, first_nx;  // opcode byte already accepted
    logic       err_orphan;
    logic       orphan_set;

    logic [7:0] own_data;
    logic       own_valid;
    logic       own_wready;
    logic [1:0] own_gnt;
    logic       rd_ready;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       discard;

`ifdef LOWSPEED_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt, wd_nx;
    logic        timed_out, to_nx;
    logic        to_fire;
    logic        err_timeout;
`else
    // Zero would make the watchdog meaningless; nothing to build here.
    if (TIMEOUT_CYCLES == 16'd0) begin : g_timeout_unused
    end
`endif

    assign own_data   = owner ? b_read_data_i   : a_read_data_i;
    assign own_valid  = owner ? b_read_valid_i  : a_read_valid_i;
    assign own_wready = owner ? b_write_ready_i : a_write_ready_i;
    assign own_gnt    = owner ? 2'b10 : 2'b01;

    always_comb begin
        state_nx           = state;
        owner_nx           = owner;
        last_b_nx          = last_b;
        args_nx            = args_left;
        first_nx           = first_done;
        rd_ready           = 1'b0;
        wr_valid           = 1'b0;
        wr_data            = 8'h00;
        grant_o            = 2'b00;
        core_read_data_o   = 8'h00;
        core_read_valid_o  = 1'b0;
        // Outside DRAIN any core response is sunk; ready only echoes valid
        // so the port stays low when nothing is offered.
        core_write_ready_o = core_write_valid_i;
`ifdef LOWSPEED_ARB_TIMEOUT_EN
        wd_nx   = wd_cnt;
        to_nx   = timed_out;
        to_fire = 1'b0;
`endif
        case (state)
            IDLE: begin
                args_nx  = 2'd0;
                first_nx = 1'b0;
`ifdef LOWSPEED_ARB_TIMEOUT_EN
                wd_nx = 16'd0;
                to_nx = 1'b0;
`endif
                if (a_read_valid_i && (!b_read_valid_i || last_b)) begin
                    owner_nx = 1'b0;
                    state_nx = CMD;
                end else if (b_read_valid_i) begin
                    owner_nx = 1'b1;
                    state_nx = CMD;
                end
            end
            CMD: begin
                grant_o           = own_gnt;
                core_read_data_o  = own_data;
                core_read_valid_o = own_valid;
                rd_ready          = core_read_ready_i;
                if (!first_done) begin
                    if (own_valid && core_read_ready_i) begin
                        first_nx = 1'b1;
                        args_nx  = own_data[7:6];
                        if (own_data[7:6] == 2'd0)
                            state_nx = GUARD;
                    end else if (!own_valid) begin
                        // Requester withdrew before committing anything.
                        state_nx = IDLE;
                    end
                end else begin
                    if (own_valid && core_read_ready_i) begin
                        if (args_left == 2'd1)
                            state_nx = GUARD;
                        else
                            args_nx = args_left - 2'd1;
                    end
`ifdef LOWSPEED_ARB_TIMEOUT_EN
                    if (own_valid) begin
                        wd_nx = 16'd0;
                    end else begin
                        wd_nx = wd_cnt + 16'd1;
                        if (wd_nx == TIMEOUT_CYCLES) begin
                            to_fire  = 1'b1;
                            to_nx    = 1'b1;
                            rd_ready = 1'b0;
                            state_nx = PAD;
                        end
                    end
`endif
                end
            end
`ifdef LOWSPEED_ARB_TIMEOUT_EN
            PAD: begin
                grant_o           = own_gnt;
                core_read_valid_o = 1'b1;
                if (core_read_ready_i) begin
                    if (args_left == 2'd1)
                        state_nx = GUARD;
                    else
                        args_nx = args_left - 2'd1;
                end
            end
`endif
            GUARD: begin
                grant_o  = own_gnt;
                state_nx = DRAIN;
            end
            DRAIN: begin
                grant_o = own_gnt;
                if (discard) begin
                    core_write_ready_o = 1'b1;
                end else begin
                    wr_valid           = core_write_valid_i;
                    wr_data            = core_write_data_i;
                    core_write_ready_o = own_wready;
                end
                if (core_read_ready_i && !core_write_valid_i) begin
                    state_nx  = IDLE;
                    last_b_nx = owner;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign orphan_set = core_write_valid_i && (state != DRAIN);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_b     <= 1'b1;
            args_left  <= 2'd0;
            first_done <= 1'b0;
            err_orphan <= 1'b0;
`ifdef LOWSPEED_ARB_TIMEOUT_EN
            wd_cnt      <= 16'd0;
            timed_out   <= 1'b0;
            err_timeout <= 1'b0;
`endif
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_b     <= last_b_nx;
            args_left  <= args_nx;
            first_done <= first_nx;
            err_orphan <= err_orphan | orphan_set;
`ifdef LOWSPEED_ARB_TIMEOUT_EN
            wd_cnt      <= wd_nx;
            timed_out   <= to_nx;
            err_timeout <= err_timeout | to_fire;
`endif
        end
    end

`ifdef LOWSPEED_ARB_TIMEOUT_EN
    assign discard         = timed_out;
    assign error_timeout_o = err_timeout;
`else
    assign discard         = 1'b0;
    assign error_timeout_o = 1'b0;
`endif

    assign a_read_ready_o  = rd_ready & ~owner;
    assign b_read_ready_o  = rd_ready & owner;
    assign a_write_valid_o = wr_valid & ~owner;
    assign b_write_valid_o = wr_valid & owner;
    assign a_write_data_o  = owner ? 8'h00 : wr_data;
    assign b_write_data_o  = owner ? wr_data : 8'h00;
    assign error_orphan_o  = err_orphan;

endmodule
